// File: rtl/chunked_addsub_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM state encodings and
// sizing helpers used by the top level.
package chunked_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A single-chunk build still needs a 1-bit counter to keep the declarations legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Operand-issue and result-consumer handshake bundle for chunked_addsub.
// master = issuer/consumer side, slave = the arithmetic unit.
interface chunked_addsub_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
  logic             o_ovf;
  logic             o_zero;

  modport master (
    output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, o_result, o_cout, o_ovf, o_zero
  );

  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    output o_ready, o_valid, o_result, o_cout, o_ovf, o_zero
  );
endinterface

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB so the
// top level can form signed overflow on the final chunk.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_result,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] sum_full;

  assign sum_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_result = sum_full[CHUNK-1:0];
  assign o_cout   = sum_full[CHUNK];
  // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out directly.
  assign o_cmsb   = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ o_result[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock through a carry register,
// with valid/ready handshakes on the operand and result sides.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  chunked_addsub_if.slave      bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = int'(cnt_width(N));
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_addsub: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end
  endgenerate

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;

  logic [IDX_W-1:0] base;
  logic [CHUNK-1:0] ca_sum;
  logic             ca_cout;
  logic             ca_cmsb;

  assign base = IDX_W'(int'(cnt_q) * CHUNK);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .i_a      (a_q[base +: CHUNK]),
    .i_b      (b_q[base +: CHUNK]),
    .i_cin    (carry_q),
    .o_result (ca_sum),
    .o_cout   (ca_cout),
    .o_cmsb   (ca_cmsb)
  );

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through the case leaves a
    // variable unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          // Subtraction is A + ~B + 1; the incoming carry is ignored in that mode.
          a_d     = bus.i_a;
          b_d     = bus.i_b ^ {WIDTH{bus.i_sub}};
          carry_d = bus.i_sub | bus.i_cin;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d[base +: CHUNK] = ca_sum;
        carry_d = ca_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d    = '0;
          result_d = acc_d;
          cout_d   = ca_cout;
          ovf_d    = ca_cmsb ^ ca_cout;
          zero_d   = (acc_d == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.o_ready  = (state_q == ST_IDLE);
  assign bus.o_valid  = (state_q == ST_DONE);
  assign bus.o_result = result_q;
  assign bus.o_cout   = cout_q;
  assign bus.o_ovf    = ovf_q;
  assign bus.o_zero   = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub: directed corner cases, backpressure,
// mid-operation reset and randomized operands against an arithmetic reference model.
module tb_chunked_addsub;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct packed {
    word_t res;
    logic  cout;
    logic  ovf;
    logic  zero;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  chunked_addsub_if #(.WIDTH(WIDTH)) bus ();

  chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values, signed range test for overflow.
  function automatic exp_t model(input word_t a, input word_t b, input logic cin, input logic sub);
    exp_t            m;
    longint          sa;
    longint          sb;
    longint          sr;
    longint          hi;
    longint          lo;
    longint unsigned ur;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -hi - 1;
    if (sub) begin
      m.res  = a - b;
      m.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      ur     = 64'(a) + 64'(b) + 64'(cin);
      m.res  = word_t'(ur);
      m.cout = ur[WIDTH];
      sr     = sa + sb + longint'(cin);
    end
    m.ovf  = (sr > hi) || (sr < lo);
    m.zero = (m.res == '0);
    return m;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  bus.o_ready,  1'b1);
    check({tag, "_valid"},  bus.o_valid,  1'b0);
    check({tag, "_result"}, bus.o_result, '0);
    check({tag, "_cout"},   bus.o_cout,   1'b0);
    check({tag, "_ovf"},    bus.o_ovf,    1'b0);
    check({tag, "_zero"},   bus.o_zero,   1'b0);
  endtask

  // Issues one operation and checks latency and result; leaves the unit in DONE when
  // consume is 0 (caller must have lowered i_ready).
  task automatic run_op(input string tag, input word_t a, input word_t b,
                        input logic cin, input logic sub, input logic consume,
                        output exp_t e);
    int lat;
    e   = model(a, b, cin, sub);
    lat = 0;
    check({tag, "_ready_in"}, bus.o_ready, 1'b1);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_cin   = cin;
    bus.i_sub   = sub;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_a     = word_t'($urandom);
    bus.i_b     = word_t'($urandom);
    bus.i_cin   = 1'($urandom);
    bus.i_sub   = 1'($urandom);
    while (!bus.o_valid && lat < 4 * N + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat,          N);
    check({tag, "_result"},  bus.o_result, e.res);
    check({tag, "_cout"},    bus.o_cout,   e.cout);
    check({tag, "_ovf"},     bus.o_ovf,    e.ovf);
    check({tag, "_zero"},    bus.o_zero,   e.zero);
    if (consume) begin
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, bus.o_valid, 1'b0);
    end
  endtask

  initial begin
    exp_t  e;
    word_t ra;
    word_t rb;

    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_cin   = 1'b0;
    bus.i_sub   = 1'b0;
    bus.i_ready = 1'b1;

    @(posedge clk); #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_release");

    run_op("add_100_55", word_t'(100), word_t'(55), 1'b0, 1'b0, 1'b1, e);
    run_op("add_cin",    word_t'(100), word_t'(55), 1'b1, 1'b0, 1'b1, e);
    run_op("add_wrap",   '1, word_t'(1), 1'b0, 1'b0, 1'b1, e);
    run_op("add_ovf",    {1'b0, {(WIDTH-1){1'b1}}}, word_t'(1), 1'b0, 1'b0, 1'b1, e);
    run_op("sub_5_7",    word_t'(5), word_t'(7), 1'b0, 1'b1, 1'b1, e);
    run_op("sub_ovf",    {1'b1, {(WIDTH-1){1'b0}}}, word_t'(1), 1'b0, 1'b1, 1'b1, e);
    run_op("sub_cin",    word_t'(5), word_t'(7), 1'b1, 1'b1, 1'b1, e);
    run_op("sub_eq",     word_t'(1234), word_t'(1234), 1'b1, 1'b1, 1'b1, e);

    // Backpressure: hold result in DONE while a new operand is offered.
    bus.i_ready = 1'b0;
    run_op("bp_op", word_t'(32'h1234_5678), word_t'(32'h0FED_CBA9), 1'b0, 1'b0, 1'b0, e);
    bus.i_valid = 1'b1;
    bus.i_a     = word_t'(7);
    bus.i_b     = word_t'(9);
    bus.i_sub   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_valid",  bus.o_valid,  1'b1);
      check("bp_ready",  bus.o_ready,  1'b0);
      check("bp_result", bus.o_result, e.res);
      check("bp_cout",   bus.o_cout,   e.cout);
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("bp_idle_valid",  bus.o_valid,  1'b0);
    check("bp_idle_ready",  bus.o_ready,  1'b1);
    check("bp_idle_retain", bus.o_result, e.res);
    @(posedge clk); #1;
    check("bp_no_capture", bus.o_ready, 1'b1);

    // Asynchronous reset two cycles into an operation.
    bus.i_valid = 1'b1;
    bus.i_a     = word_t'(11);
    bus.i_b     = word_t'(22);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", word_t'(200), word_t'(300), 1'b0, 1'b0, 1'b1, e);

    for (int i = 0; i < 100; i++) begin
      ra = word_t'($urandom);
      rb = word_t'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = ~ra;
        1:       ra = '1;
        2:       rb = ra;
        default: ;
      endcase
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom), 1'b1, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
